rx_comma_aligner: RTL and testbench

- Receive-side stage placed directly upstream of the 10-bit-to-8-bit decoder.
- Takes the serial bit stream produced from the encoder's 10-bit code groups and finds K28.5 comma boundaries.
- Deserializes the stream into aligned 10-bit words for the decoder, with a valid strobe and a lock indication.
- Bit order matches the encoder output vector {a,b,c,d,e,i,f,g,h,j}: the first bit received lands in oData[9], the last in oData[0].

---
 rtl/rx_comma_aligner.sv | 143 ++++++++++++++
 tb/tb_rx_comma_aligner.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_comma_aligner.sv
// Receive comma aligner: hunts for K28.5 in the serial stream and deserializes aligned
// 10-bit code groups for the decoder (first received bit lands in oData[9]).
module rx_comma_aligner #(
  parameter int SYNC_COMMAS = 3,
  parameter int LOSS_WORDS  = 64
) (
  input  logic       INTERCLK,
  input  logic       Reset,
  input  logic       iSerial,
  input  logic       iBitEn,
  output logic [9:0] oData,
  output logic       oValid,
  output logic       oComma,
  output logic       oSync
);
  // state   | meaning
  // HUNT    | searching every bit position for a comma, no words emitted
  // ACQUIRE | comma found, counting identically aligned commas, no words emitted
  // SYNC    | locked, one word emitted per 10 enabled bits
  typedef enum logic [1:0] {HUNT = 2'd0, ACQUIRE = 2'd1, SYNC = 2'd2} state_t;

  localparam logic [9:0] COMMA_NEG = 10'b0011111010;
  localparam logic [9:0] COMMA_POS = 10'b1100000101;
  localparam logic [3:0] GCNT_LOCK = 4'(SYNC_COMMAS);
  localparam logic [9:0] WCNT_LOSS = 10'(LOSS_WORDS);

  state_t     state_q;
  logic [9:0] sr_q;
  logic [3:0] cnt_q;
  logic [3:0] gcnt_q;
  logic [9:0] wcnt_q;
  logic [9:0] data_q;
  logic       valid_q;
  logic       comma_q;
  logic       sync_q;

  logic [9:0] sr_d;
  logic       is_comma;
  logic       boundary;
  logic [3:0] cnt_inc;
  logic [3:0] gcnt_inc;
  logic [9:0] wcnt_inc;

  // All decisions look at the shift register including the bit arriving this cycle
  assign sr_d     = {sr_q[8:0], iSerial};
  assign is_comma = (sr_d == COMMA_NEG) || (sr_d == COMMA_POS);
  assign boundary = (cnt_q == 4'd9);
  assign cnt_inc  = boundary ? 4'd0 : cnt_q + 4'd1;
  assign gcnt_inc = gcnt_q + 4'd1;
  assign wcnt_inc = wcnt_q + 10'd1;

  always_ff @(posedge INTERCLK) begin
    if (!Reset) begin
      state_q <= HUNT;
      sr_q    <= 10'd0;
      cnt_q   <= 4'd0;
      gcnt_q  <= 4'd0;
      wcnt_q  <= 10'd0;
      data_q  <= 10'd0;
      valid_q <= 1'b0;
      comma_q <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      comma_q <= 1'b0;
      if (iBitEn) begin
        sr_q  <= sr_d;
        cnt_q <= cnt_inc;
        case (state_q)
          HUNT: begin
            if (is_comma) begin
              cnt_q  <= 4'd0;
              gcnt_q <= 4'd1;
              wcnt_q <= 10'd0;
              if (SYNC_COMMAS == 1) begin
                state_q <= SYNC;
                sync_q  <= 1'b1;
                data_q  <= sr_d;
                valid_q <= 1'b1;
                comma_q <= 1'b1;
              end else begin
                state_q <= ACQUIRE;
              end
            end
          end
          ACQUIRE: begin
            if (is_comma && !boundary) begin
              cnt_q  <= 4'd0;
              gcnt_q <= 4'd1;
            end else if (boundary) begin
              if (is_comma) begin
                gcnt_q <= gcnt_inc;
                if (gcnt_inc == GCNT_LOCK) begin
                  state_q <= SYNC;
                  sync_q  <= 1'b1;
                  data_q  <= sr_d;
                  valid_q <= 1'b1;
                  comma_q <= 1'b1;
                  wcnt_q  <= 10'd0;
                end
              end else begin
                state_q <= HUNT;
                gcnt_q  <= 4'd0;
              end
            end
          end
          SYNC: begin
            if (boundary) begin
              data_q  <= sr_d;
              valid_q <= 1'b1;
              comma_q <= is_comma;
              if (is_comma) begin
                wcnt_q <= 10'd0;
              end else begin
                wcnt_q <= wcnt_inc;
                // Timeout word is still delivered; lock drops afterwards
                if (LOSS_WORDS != 0 && wcnt_inc == WCNT_LOSS) begin
                  state_q <= HUNT;
                  sync_q  <= 1'b0;
                end
              end
            end else if (is_comma) begin
              state_q <= ACQUIRE;
              sync_q  <= 1'b0;
              cnt_q   <= 4'd0;
              gcnt_q  <= 4'd1;
            end
          end
          default: begin
            state_q <= HUNT;
            sync_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oComma = comma_q;
  assign oSync  = sync_q;

endmodule

// File: tb/tb_rx_comma_aligner.sv
// Self-checking bench for rx_comma_aligner: scoreboard of expected words with their
// emission edge, plus a second instance with a short loss timeout.
module tb_rx_comma_aligner;
  logic       INTERCLK = 1'b0;
  logic       Reset    = 1'b0;
  logic       iSerial  = 1'b0;
  logic       iBitEn   = 1'b0;
  logic [9:0] oData;
  logic       oValid;
  logic       oComma;
  logic       oSync;
  logic [9:0] l_data;
  logic       l_valid;
  logic       l_comma;
  logic       l_sync;

  typedef struct {
    logic [9:0] data;
    logic       comma;
    int         when;
  } exp_t;

  exp_t       sb_q[$];
  int         errors = 0;
  int         checks = 0;
  int         edge_n = 0;
  int         lv_cnt = 0;
  logic [9:0] lv_data = 10'd0;

  rx_comma_aligner #(.SYNC_COMMAS(3), .LOSS_WORDS(64)) dut (
    .INTERCLK(INTERCLK), .Reset(Reset), .iSerial(iSerial), .iBitEn(iBitEn),
    .oData(oData), .oValid(oValid), .oComma(oComma), .oSync(oSync)
  );

  rx_comma_aligner #(.SYNC_COMMAS(3), .LOSS_WORDS(4)) dut_l (
    .INTERCLK(INTERCLK), .Reset(Reset), .iSerial(iSerial), .iBitEn(iBitEn),
    .oData(l_data), .oValid(l_valid), .oComma(l_comma), .oSync(l_sync)
  );

  always #5 INTERCLK = ~INTERCLK;

  task automatic tick(input logic s, input logic en, input logic rst);
    iSerial = s;
    iBitEn  = en;
    Reset   = rst;
    @(posedge INTERCLK);
    #1;
    edge_n++;
  endtask

  task automatic push(input logic [9:0] w, input logic cm);
    exp_t e;
    e.data  = w;
    e.comma = cm;
    e.when  = edge_n + 1;
    sb_q.push_back(e);
  endtask

  task automatic send_word(input logic [9:0] w, input logic emit, input logic cm);
    for (int i = 9; i >= 0; i--) begin
      if (i == 0 && emit) push(w, cm);
      tick(w[i], 1'b1, 1'b1);
    end
  endtask

  task automatic send_word_gaps(input logic [9:0] w, input logic cm);
    for (int i = 9; i >= 0; i--) begin
      int g = 0;
      while (g < 4 && $urandom_range(0, 1) == 1) begin
        tick(1'($urandom_range(0, 1)), 1'b0, 1'b1);
        g++;
      end
      if (i == 0) push(w, cm);
      tick(w[i], 1'b1, 1'b1);
    end
  endtask

  task automatic check_sync(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Pops one expectation per emitted word and flags missing, extra or late words
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge INTERCLK);
      if (l_valid === 1'b1) begin
        lv_cnt++;
        lv_data = l_data;
      end
      checks++;
      if (oComma === 1'b1 && oValid !== 1'b1) begin
        errors++;
        $display("FAIL comma_qual: oComma=1 with oValid=%b at edge %0d, required 0", oValid, edge_n);
      end
      if (oValid === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got data=%h comma=%b at edge %0d, required no word",
                   oData, oComma, edge_n);
        end else begin
          e = sb_q.pop_front();
          if (oData !== e.data || oComma !== e.comma || e.when != edge_n) begin
            errors++;
            $display("FAIL word: got data=%h comma=%b edge=%0d, required data=%h comma=%b edge=%0d",
                     oData, oComma, edge_n, e.data, e.comma, e.when);
          end
        end
      end else if (sb_q.size() != 0 && sb_q[0].when <= edge_n) begin
        checks++;
        errors++;
        e = sb_q.pop_front();
        $display("FAIL missing_word: got no word at edge %0d, required data=%h comma=%b at edge %0d",
                 edge_n, e.data, e.comma, e.when);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      checks++;
      if (oValid !== 1'b0 || oSync !== 1'b0 || oData !== 10'd0 || oComma !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: got valid=%b sync=%b data=%h comma=%b, required all 0",
                 oValid, oSync, oData, oComma);
      end
    end
  endtask

  task automatic test_lock();
    logic [3:0] pre;
    pre = 4'b1011;
    for (int i = 3; i >= 0; i--) tick(pre[i], 1'b1, 1'b1);
    send_word(10'h0FA, 1'b0, 1'b0);
    check_sync("lock_after_1st", oSync, 1'b0);
    send_word(10'h0FA, 1'b0, 1'b0);
    check_sync("lock_after_2nd", oSync, 1'b0);
    send_word(10'h0FA, 1'b1, 1'b1);
    check_sync("lock_after_3rd", oSync, 1'b1);
    for (int i = 0; i < 5; i++) send_word(10'h2AA, 1'b1, 1'b0);
    check_sync("lock_hold", oSync, 1'b1);
  endtask

  task automatic test_misalign();
    logic [9:0] c;
    c = 10'h305;
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    // The boundary falls after the comma's 7th bit, so a junk word is still delivered
    for (int i = 9; i >= 0; i--) begin
      if (i == 3) push(10'h2E0, 1'b0);
      tick(c[i], 1'b1, 1'b1);
      if (i == 1) check_sync("misalign_before", oSync, 1'b1);
    end
    check_sync("misalign_drop", oSync, 1'b0);
    send_word(10'h305, 1'b0, 1'b0);
    check_sync("misalign_acq", oSync, 1'b0);
    send_word(10'h305, 1'b1, 1'b1);
    check_sync("misalign_relock", oSync, 1'b1);
    send_word(10'h2AA, 1'b1, 1'b0);
  endtask

  task automatic test_gaps();
    logic [9:0] words[10];
    logic [9:0] w;
    words = '{10'h2AA, 10'h155, 10'h305, 10'h2AA, 10'h0FA,
              10'h155, 10'h2AA, 10'h305, 10'h155, 10'h2AA};
    for (int k = 0; k < 10; k++) begin
      w = words[k];
      send_word_gaps(w, (w == 10'h0FA || w == 10'h305));
    end
    check_sync("gaps_sync", oSync, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [9:0] w;
    w = 10'h2AA;
    for (int i = 9; i >= 4; i--) tick(w[i], 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    checks++;
    if (oValid !== 1'b0 || oSync !== 1'b0 || oData !== 10'd0 || oComma !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b sync=%b data=%h comma=%b, required all 0",
               oValid, oSync, oData, oComma);
    end
    send_word(10'h0FA, 1'b0, 1'b0);
    send_word(10'h0FA, 1'b0, 1'b0);
    check_sync("relock_after_2nd", oSync, 1'b0);
    send_word(10'h0FA, 1'b1, 1'b1);
    check_sync("relock_after_3rd", oSync, 1'b1);
    send_word(10'h155, 1'b1, 1'b0);
  endtask

  task automatic test_loss();
    int base;
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    base = lv_cnt;
    send_word(10'h305, 1'b0, 1'b0);
    send_word(10'h305, 1'b0, 1'b0);
    send_word(10'h305, 1'b1, 1'b1);
    check_sync("loss_locked", l_sync, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      send_word(10'h155, 1'b1, 1'b0);
      if (k == 3) check_sync("loss_before_timeout", l_sync, 1'b1);
      if (k == 4) begin
        check_sync("loss_timeout_sync", l_sync, 1'b0);
        check_sync("loss_4th_valid", l_valid, 1'b1);
      end
      if (k == 5) check_sync("loss_5th_valid", l_valid, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b1);
    checks++;
    if (lv_cnt - base != 5 || lv_data !== 10'h155) begin
      errors++;
      $display("FAIL loss_count: got %0d words last=%h, required 5 words last=155",
               lv_cnt - base, lv_data);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_lock();
    test_misalign();
    test_gaps();
    test_reset_mid();
    test_loss();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending words, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
